// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG result path: the controller's command encodings,
// the result width, the entry tag values, the FIFO entry layout and the health test.
package trng_pkg;

   localparam int unsigned MEM_W   = 144;
   localparam int unsigned CHUNK_W = 16;
   localparam int unsigned NCHUNK  = MEM_W / CHUNK_W;

   localparam logic [1:0] CMD_TRNG    = 2'b00;
   localparam logic [1:0] CMD_SET_VAR = 2'b01;
   localparam logic [1:0] CMD_WRITE   = 2'b10;
   localparam logic [1:0] CMD_READ    = 2'b11;

   localparam logic TAG_TRNG = 1'b1;
   localparam logic TAG_READ = 1'b0;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } ser_state_e;

   typedef struct packed {
      logic             tag;
      logic [MEM_W-1:0] data;
   } entry_t;

   // A TRNG result is rejected when it is stuck at all-0 or all-1, or when any
   // two neighbouring 16-bit chunks repeat.
   function automatic logic health_bad(input logic [MEM_W-1:0] d);
      logic bad;
      bad = (d == '0) || (&d);
      for (int k = 0; k < int'(NCHUNK) - 1; k++) begin
         if (CHUNK_W'(d >> (CHUNK_W * k)) == CHUNK_W'(d >> (CHUNK_W * (k + 1))))
            bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/trng_entry_fifo.sv
// DEPTH x entry_t synchronous FIFO with extended-bit pointers.
// Ports: clk, rstn (async active-low), clr (sync flush), push/wdata, pop,
//        rdata (head entry), full, empty, level (stored entries).
// push and pop must already be qualified by the caller (no push when full
// unless popping, no pop when empty).
module trng_entry_fifo
   import trng_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             push,
   input  entry_t           wdata,
   input  logic             pop,
   output entry_t           rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int unsigned AW = $clog2(DEPTH);

   entry_t         mem_q [DEPTH];
   logic [AW:0]    wr_cnt_q, wr_cnt_d;
   logic [AW:0]    rd_cnt_q, rd_cnt_d;

   // Pointer update; the extra MSB distinguishes full from empty.
   always_comb begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (clr) begin
         wr_cnt_d = '0;
         rd_cnt_d = '0;
      end else begin
         if (push) wr_cnt_d = wr_cnt_q + (AW+1)'(1);
         if (pop)  rd_cnt_d = rd_cnt_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   // Storage carries no reset; contents are only observed while level != 0.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_cnt_q[AW-1:0]] <= wdata;
   end

   assign level = wr_cnt_q - rd_cnt_q;
   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);
   assign rdata = mem_q[rd_cnt_q[AW-1:0]];

endmodule

// File: rtl/trng_result_buffer.sv
// Buffers completed READ/TRNG results from the controller and streams each one
// to the host as MEM_W/WORD_W words, LSB word first, over valid/ready.
// Ports: clk, rstn (async active-low); mem_out/done/err/cmd from the controller;
//        clr sync flush; rd_data/rd_valid/rd_ready/rd_last/rd_tag host stream;
//        level stored entries; overflow sticky drop flag; health_fail sticky.
// Build option: define TRNG_HEALTH_EN to reject TRNG results failing the
//        stuck/repeat health test; otherwise health_fail is tied to 0.
module trng_result_buffer
   import trng_pkg::*;
#(
   parameter  int unsigned DEPTH  = 4,
   parameter  int unsigned WORD_W = 16,
   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [MEM_W-1:0]  mem_out,
   input  logic              done,
   input  logic              err,
   input  logic [1:0]        cmd,
   input  logic              clr,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last,
   output logic              rd_tag,
   output logic [LVL_W-1:0]  level,
   output logic              overflow,
   output logic              health_fail
);

   localparam int unsigned NWORDS = MEM_W / WORD_W;
   localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

   ser_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             done_q;
   logic             overflow_q, overflow_d;

   logic             capture, qualify, hbad, push_req, push, xfer, pop;
   logic             fifo_full, fifo_empty;
   entry_t           wr_entry, head;
   logic [WORD_W-1:0] words [NWORDS];

   // Rising edge of done marks one completion, however long done is held.
   assign capture = done & ~done_q;
   assign qualify = capture & ~err & ((cmd == CMD_TRNG) || (cmd == CMD_READ)) & ~clr;

`ifdef TRNG_HEALTH_EN
   logic health_q;

   assign hbad = (cmd == CMD_TRNG) && health_bad(mem_out);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                 health_q <= 1'b0;
      else if (clr)              health_q <= 1'b0;
      else if (qualify && hbad)  health_q <= 1'b1;
   end

   assign health_fail = health_q;
`else
   assign hbad        = 1'b0;
   assign health_fail = 1'b0;
`endif

   assign push_req = qualify & ~hbad;
   assign xfer     = rd_valid & rd_ready;
   assign pop      = xfer & (idx_q == IDX_LAST) & ~clr;
   // A full FIFO still accepts when its head leaves on the same edge.
   assign push     = push_req & (~fifo_full | pop);

   assign wr_entry.tag  = (cmd == CMD_TRNG) ? TAG_TRNG : TAG_READ;
   assign wr_entry.data = mem_out;

   trng_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Serializer next state, word index and overflow flag.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      overflow_d = overflow_q;
      if (clr) begin
         state_d    = ST_IDLE;
         idx_d      = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_req && fifo_full && !pop) overflow_d = 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (push) state_d = ST_STREAM;
            end
            ST_STREAM: begin
               if (xfer) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
               if (pop && (level == LVL_W'(1)) && !push) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         done_q     <= done;
         overflow_q <= overflow_d;
      end
   end

   for (genvar g = 0; g < int'(NWORDS); g++) begin : g_words
      assign words[g] = head.data[g*WORD_W +: WORD_W];
   end

   assign rd_valid = (state_q == ST_STREAM);
   assign rd_data  = fifo_empty ? '0 : words[idx_q];
   assign rd_tag   = ~fifo_empty & head.tag;
   assign rd_last  = rd_valid & (idx_q == IDX_LAST);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_trng_result_buffer.sv
// Directed self-checking bench for trng_result_buffer (DEPTH=4, WORD_W=16).
module tb_trng_result_buffer;
   import trng_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned NW     = 9;

   logic         clk = 1'b0;
   logic         rstn;
   logic [143:0] mem_out;
   logic         done, err, clr, rd_ready;
   logic [1:0]   cmd;
   logic [15:0]  rd_data;
   logic         rd_valid, rd_last, rd_tag, overflow, health_fail;
   logic [2:0]   level;

   int n_checks = 0;
   int n_fail   = 0;

   trng_result_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
      .clk(clk), .rstn(rstn), .mem_out(mem_out), .done(done), .err(err),
      .cmd(cmd), .clr(clr), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_last(rd_last), .rd_tag(rd_tag),
      .level(level), .overflow(overflow), .health_fail(health_fail)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   cmd;
      logic         err;
      logic [143:0] data;
      logic         exp_push;
      logic         exp_tag;
   } vec_t;

   vec_t        tbl [6];
   logic [15:0] spec_w [9];

   task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Distinct, health-clean payload: chunk k = {s, k+1}.
   function automatic logic [143:0] mk(input logic [7:0] s);
      logic [143:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) r = r | (144'({s, 8'(k + 1)}) << (16 * k));
      return r;
   endfunction

   function automatic logic [15:0] word_of(input logic [143:0] d, input int w);
      return 16'(d >> (16 * w));
   endfunction

   task automatic capture(input logic [1:0] c, input logic e, input logic [143:0] d);
      cmd = c; err = e; mem_out = d; done = 1'b1;
      tick();
      done = 1'b0; err = 1'b0;
      tick();
   endtask

   task automatic read_entry(input string nm, input logic [143:0] d, input logic tag);
      rd_ready = 1'b1;
      for (int w = 0; w < int'(NW); w++) begin
         chk({nm, ".valid"}, 144'(rd_valid), 144'(1));
         chk({nm, ".data"},  144'(rd_data),  144'(word_of(d, w)));
         chk({nm, ".last"},  144'(rd_last),  144'(w == int'(NW) - 1));
         chk({nm, ".tag"},   144'(rd_tag),   144'(tag));
         tick();
      end
      rd_ready = 1'b0;
   endtask

   initial begin
      spec_w = '{16'h6789, 16'h2345, 16'h3211, 16'h7654, 16'h8998,
                 16'h4567, 16'h1123, 16'h5432, 16'h9876};
      tbl[0] = '{CMD_READ,    1'b0, 144'h987654321123456789987654321123456789, 1'b1, 1'b0};
      tbl[1] = '{CMD_WRITE,   1'b0, mk(8'hA1), 1'b0, 1'b0};
      tbl[2] = '{CMD_READ,    1'b1, mk(8'hA2), 1'b0, 1'b0};
      tbl[3] = '{CMD_SET_VAR, 1'b0, mk(8'hA3), 1'b0, 1'b0};
      tbl[4] = '{CMD_TRNG,    1'b0, mk(8'hA4), 1'b1, 1'b1};
      tbl[5] = '{CMD_TRNG,    1'b1, mk(8'hA5), 1'b0, 1'b0};

      rstn = 1'b0; done = 1'b0; err = 1'b0; clr = 1'b0; rd_ready = 1'b0;
      cmd = CMD_TRNG; mem_out = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid",  144'(rd_valid),    144'(0));
      chk("rst.data",   144'(rd_data),     144'(0));
      chk("rst.last",   144'(rd_last),     144'(0));
      chk("rst.tag",    144'(rd_tag),      144'(0));
      chk("rst.level",  144'(level),       144'(0));
      chk("rst.ovf",    144'(overflow),    144'(0));
      chk("rst.health", 144'(health_fail), 144'(0));
      @(negedge clk) rstn = 1'b1;
      tick();

      // Hand-derived word sequence of the reference READ result.
      cmd = CMD_READ; mem_out = tbl[0].data; done = 1'b1;
      tick();
      done = 1'b0;
      chk("lat.valid", 144'(rd_valid), 144'(1));
      rd_ready = 1'b1;
      for (int w = 0; w < int'(NW); w++) begin
         chk("spec.word", 144'(rd_data), 144'(spec_w[w]));
         chk("spec.last", 144'(rd_last), 144'(w == 8));
         chk("spec.tag",  144'(rd_tag),  144'(0));
         tick();
      end
      rd_ready = 1'b0;
      chk("spec.level", 144'(level), 144'(0));
      chk("spec.valid", 144'(rd_valid), 144'(0));

      // Qualification table.
      for (int i = 0; i < 6; i++) begin
         capture(tbl[i].cmd, tbl[i].err, tbl[i].data);
         chk("tbl.level", 144'(level),    144'(tbl[i].exp_push));
         chk("tbl.valid", 144'(rd_valid), 144'(tbl[i].exp_push));
         chk("tbl.ovf",   144'(overflow), 144'(0));
         if (tbl[i].exp_push) begin
            read_entry("tbl", tbl[i].data, tbl[i].exp_tag);
            chk("tbl.drained", 144'(level), 144'(0));
         end
      end

      // Overflow: five captures into a four-deep FIFO with the host stalled.
      for (int i = 0; i < 5; i++) begin
         capture(CMD_TRNG, 1'b0, mk(8'(8'h10 + i)));
         chk("ovf.level", 144'(level),    144'(i < 4 ? i + 1 : 4));
         chk("ovf.flag",  144'(overflow), 144'(i == 4));
      end
      chk("stall.data0", 144'(rd_data), 144'(word_of(mk(8'h10), 0)));
      tick();
      chk("stall.data1", 144'(rd_data), 144'(word_of(mk(8'h10), 0)));
      chk("stall.tag",   144'(rd_tag),  144'(1));
      for (int i = 0; i < 4; i++) read_entry("ovf.drain", mk(8'(8'h10 + i)), 1'b1);
      chk("ovf.empty",  144'(level),    144'(0));
      chk("ovf.sticky", 144'(overflow), 144'(1));
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr.ovf", 144'(overflow), 144'(0));

      // Full FIFO, capture lands on the rd_last transfer.
      for (int i = 0; i < 4; i++) capture(CMD_TRNG, 1'b0, mk(8'(8'h20 + i)));
      chk("full.level", 144'(level), 144'(4));
      rd_ready = 1'b1;
      for (int w = 0; w < int'(NW); w++) begin
         if (w == int'(NW) - 1) begin
            cmd = CMD_TRNG; mem_out = mk(8'h24); done = 1'b1;
         end
         chk("full.word", 144'(rd_data), 144'(word_of(mk(8'h20), w)));
         tick();
      end
      done = 1'b0; rd_ready = 1'b0;
      chk("full.level2", 144'(level),    144'(4));
      chk("full.ovf",    144'(overflow), 144'(0));
      for (int i = 1; i < 5; i++) read_entry("full.drain", mk(8'(8'h20 + i)), 1'b1);
      chk("full.empty", 144'(level), 144'(0));

      // done held high: one capture only; then flush mid-entry.
      cmd = CMD_TRNG; mem_out = mk(8'h30); done = 1'b1;
      repeat (10) tick();
      done = 1'b0;
      tick();
      chk("hold.level", 144'(level),  144'(1));
      chk("hold.tag",   144'(rd_tag), 144'(1));
      rd_ready = 1'b1;
      repeat (3) tick();
      rd_ready = 1'b0;
      chk("hold.idx3", 144'(rd_data), 144'(word_of(mk(8'h30), 3)));
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr.level", 144'(level),    144'(0));
      chk("clr.valid", 144'(rd_valid), 144'(0));
      chk("clr.data",  144'(rd_data),  144'(0));
      // Capture coinciding with clr is discarded.
      cmd = CMD_READ; mem_out = mk(8'h31); done = 1'b1; clr = 1'b1;
      tick();
      done = 1'b0; clr = 1'b0;
      tick();
      chk("clrcap.level", 144'(level), 144'(0));

      // Stuck-at-zero TRNG result.
      capture(CMD_TRNG, 1'b0, '0);
`ifdef TRNG_HEALTH_EN
      chk("hlth.level", 144'(level),       144'(0));
      chk("hlth.flag",  144'(health_fail), 144'(1));
`else
      chk("hlth.level", 144'(level),       144'(1));
      chk("hlth.flag",  144'(health_fail), 144'(0));
      chk("hlth.tag",   144'(rd_tag),      144'(1));
`endif
      clr = 1'b1; tick(); clr = 1'b0;
      chk("hlth.clr",   144'(health_fail), 144'(0));
      chk("hlth.empty", 144'(level),       144'(0));

      // Asynchronous reset in the middle of an entry.
      capture(CMD_READ, 1'b0, mk(8'h40));
      rd_ready = 1'b1;
      repeat (2) tick();
      chk("mid.word2", 144'(rd_data), 144'(word_of(mk(8'h40), 2)));
      #2 rstn = 1'b0;
      #1;
      chk("arst.valid", 144'(rd_valid), 144'(0));
      chk("arst.data",  144'(rd_data),  144'(0));
      chk("arst.level", 144'(level),    144'(0));
      @(negedge clk) rstn = 1'b1;
      tick();
      chk("arst.after", 144'(rd_valid), 144'(0));
      rd_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
